// File: rtl/aer_pkg.sv
// rtl/aer_pkg.sv - shared FSM states and DAVIS240C bus defaults for the AER front-end
package aer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CAPTURE,
        WAIT_REL
    } aer_state_e;

    localparam int             AER_W        = 9;
    localparam logic [AER_W-1:0] AER_INV_MASK = 9'b0_1100_0000;

endpackage

// File: rtl/aer_bus_conditioner_if.sv
// rtl/aer_bus_conditioner_if.sv - sensor handshake pins and downstream event stream
interface aer_bus_conditioner_if
    import aer_pkg::*;
#(
    parameter int DATA_W = AER_W
);
    logic [DATA_W-1:0] aer_bus;
    logic              aer_req;
    logic              aer_ack;
    logic [DATA_W-1:0] evt_data;
    logic              evt_valid;
    logic              evt_ready;

    modport master (
        input  aer_bus, aer_req, evt_ready,
        output aer_ack, evt_data, evt_valid
    );

    modport slave (
        output aer_bus, aer_req, evt_ready,
        input  aer_ack, evt_data, evt_valid
    );
endinterface

// File: rtl/aer_evt_fifo.sv
// rtl/aer_evt_fifo.sv - first-word-fall-through event FIFO, power-of-2 depth
module aer_evt_fifo #(
    parameter int DATA_W     = 9,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          pop,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              push_ok, pop_ok;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LW'(FIFO_DEPTH));
    assign level   = level_q;
    assign pop_ok  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO may still accept.
    assign push_ok = push & (~full | pop_ok);
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wr_data;
    end
endmodule

// File: rtl/aer_bus_conditioner.sv
// rtl/aer_bus_conditioner.sv - AER REQ synchroniser, 4-phase ACK FSM and bus polarity conditioning
module aer_bus_conditioner
    import aer_pkg::*;
#(
    parameter int                DATA_W         = AER_W,
    parameter logic [DATA_W-1:0] INV_MASK       = DATA_W'(AER_INV_MASK),
    parameter int                SYNC_STAGES    = 2,
    parameter int                SETTLE_CYC     = 2,
    parameter int                FIFO_DEPTH     = 4,
    parameter bit                REQ_ACTIVE_LOW = 1'b1,
    parameter bit                ACK_ACTIVE_LOW = 1'b1,
    parameter bit                DROP_ON_FULL   = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    aer_bus_conditioner_if.master        aer,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic [15:0]                  drop_cnt,
    output logic                         busy
);
    localparam int   CNT_W  = $clog2(SETTLE_CYC + 1);
    localparam logic ACK_ON = !ACK_ACTIVE_LOW;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   req_s;
    aer_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ack_q, ack_d;
    logic [15:0]            drop_q, drop_d;
    logic                   push, pop, full, empty;
    logic [DATA_W-1:0]      cond_word, rd_data;

    // REQ is normalised to active-high before the first flop so reset holds "inactive".
    assign sync_d    = {sync_q[SYNC_STAGES-2:0], aer.aer_req ^ REQ_ACTIVE_LOW};
    assign req_s     = sync_q[SYNC_STAGES-1];
    assign cond_word = aer.aer_bus ^ INV_MASK;
    assign pop       = ~empty & aer.evt_ready;

    assign aer.aer_ack   = ack_q;
    assign aer.evt_data  = rd_data;
    assign aer.evt_valid = ~empty;
    assign drop_cnt      = drop_q;
    assign busy          = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = ack_q;
        drop_d  = drop_q;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_s) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end
            end
            SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYC - 1)) state_d = CAPTURE;
                else                                 cnt_d   = cnt_q + 1'b1;
            end
            CAPTURE: begin
                if (!full || pop) begin
                    push    = 1'b1;
                    ack_d   = ACK_ON;
                    state_d = WAIT_REL;
                end else if (DROP_ON_FULL) begin
                    ack_d   = ACK_ON;
                    state_d = WAIT_REL;
                    if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
                end
            end
            WAIT_REL: begin
                if (!req_s) begin
                    ack_d   = ~ACK_ON;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            ack_q   <= ~ACK_ON;
            drop_q  <= '0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            drop_q  <= drop_d;
        end
    end

    aer_evt_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data (cond_word),
        .pop     (pop),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty),
        .level   (fifo_level)
    );
endmodule

// File: doc/aer_bus_conditioner.md
Name: aer_bus_conditioner

Overview:
- Parametrised next-generation AER front-end for the DAVIS240C event interface.
- Conditions the sensor's address bus with a per-bit polarity mask and synchronises the asynchronous sensor REQ.
- Runs the 4-phase REQ/ACK handshake toward the sensor and buffers captured events in a small FIFO with a valid/ready output.
- Sits between the sensor pins and the downstream event decoder.

Parameters:
- DATA_W, 9: AER bus width in bits.
- INV_MASK, 9'b0_1100_0000: bit i set means bus bit i is inverted; the default inverts bits 6 and 7. Width is DATA_W.
- SYNC_STAGES, 2: flip-flop stages on aer_req; minimum 2.
- SETTLE_CYC, 2: clk cycles between the synchronised REQ assertion and the data capture; minimum 1.
- FIFO_DEPTH, 4: event FIFO entries; must be a power of 2, minimum 2.
- REQ_ACTIVE_LOW, 1: sensor REQ polarity.
- ACK_ACTIVE_LOW, 1: sensor ACK polarity.
- DROP_ON_FULL, 0: 0 = stall the handshake while the FIFO is full; 1 = acknowledge and discard the event.

Ports:
- clk, input, 1: single system clock. All logic is on its rising edge.
- rst_n, input, 1: asynchronous, active-low reset. The block is held in reset while it is 0.
- aer_bus, input, DATA_W: raw sensor address/polarity bus. Bundled data, stable while REQ is asserted.
- aer_req, input, 1: sensor request, asynchronous.
- aer_ack, output, 1: sensor acknowledge, registered.
- evt_data, output, DATA_W: conditioned event word (FIFO head).
- evt_valid, output, 1: FIFO is not empty.
- evt_ready, input, 1: downstream accepts evt_data.
- fifo_level, output, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- drop_cnt, output, 16: saturating count of dropped events.
- busy, output, 1: FSM is not in IDLE.

Behaviour:
- Reset values:
  - aer_ack is at its inactive level: 1 when ACK_ACTIVE_LOW=1, otherwise 0.
  - evt_valid=0, fifo_level=0, drop_cnt=0, busy=0.
  - evt_data is 0.
  - FSM is in IDLE and the synchroniser flops hold the inactive REQ level.
- Synchronisation and data conditioning:
  - req_s is aer_req normalised to active-high and passed through SYNC_STAGES flops.
  - Data is not synchronised. It is sampled directly as aer_bus ^ INV_MASK in the capture cycle; the bundled-data rule guarantees stability.
- FSM states:
  - IDLE: when req_s=1, go to SETTLE and clear the settle counter.
  - SETTLE: count up to SETTLE_CYC-1, then go to CAPTURE.
  - CAPTURE:
    - FIFO not full: push the conditioned word, assert aer_ack, go to WAIT_REL.
    - FIFO full, DROP_ON_FULL=0: remain in CAPTURE with ACK inactive, re-evaluating every cycle.
    - FIFO full, DROP_ON_FULL=1: assert aer_ack, increment drop_cnt (saturating at 16'hFFFF), no push, go to WAIT_REL.
  - WAIT_REL: hold aer_ack active until req_s=0, then deassert aer_ack and go to IDLE.
  - Exactly one capture happens per REQ assertion.
- aer_ack is registered; it asserts on the clk edge following entry into CAPTURE with space available.
- Minimum latency:
  - REQ edge to ACK: SYNC_STAGES + SETTLE_CYC + 1 cycles, plus the synchroniser phase.
  - Push to evt_valid: 1 cycle.
- FIFO:
  - First-word-fall-through; evt_data equals the head entry whenever evt_valid=1.
  - A pop occurs when evt_valid & evt_ready.
  - Simultaneous push and pop in the same cycle is legal, including when the FIFO is full (pop frees the slot that cycle): level is unchanged and order is preserved.
  - Pointers wrap modulo FIFO_DEPTH.
  - evt_ready with an empty FIFO is a no-op.
- Reset asserted mid-handshake: immediately returns to the reset state. ACK drops to inactive asynchronously and FIFO contents are discarded.
- REQ deasserted before CAPTURE (protocol violation): the FSM still completes capture and ACK, and WAIT_REL then exits on the next cycle. No hang.

Decomposition:
- Package aer_pkg holds:
  - the FSM state enum (IDLE, SETTLE, CAPTURE, WAIT_REL);
  - the DAVIS240C default constants: AER_W=9, AER_INV_MASK.
- One sub-module, aer_evt_fifo: parametrised FWFT FIFO (DATA_W, FIFO_DEPTH) with push, pop, full, empty and level.

Test Plan:
1. Single event, defaults (active-low REQ/ACK, INV_MASK bits 6 and 7):
   - Stimulus: aer_bus=9'h0C5, drive aer_req low.
   - Required: aer_ack goes low 5 cycles after the REQ edge reaches flop 1; evt_data=9'h005, evt_valid=1.
   - Then release REQ: aer_ack returns to 1 and busy=0.
2. Backpressure, DROP_ON_FULL=0, evt_ready=0:
   - Stimulus: 5 handshakes.
   - Required: 4 acknowledged, fifo_level=4, the 5th stalls in CAPTURE with aer_ack=1.
   - Then pulse evt_ready for 1 cycle: the 5th is acknowledged and fifo_level stays 4.
3. Drop mode, DROP_ON_FULL=1, evt_ready=0:
   - Stimulus: 6 events.
   - Required: all 6 acknowledged, fifo_level=4, drop_cnt=2, FIFO holds the first 4 words in order.
4. Streaming, evt_ready=1:
   - Stimulus: 20 events with words 0..19 (post-mask).
   - Required: output sequence 0..19, no drops, pointers wrap correctly.
5. Reset mid-handshake:
   - Stimulus: assert rst_n=0 in WAIT_REL.
   - Required: aer_ack inactive within the same cycle (asynchronous), evt_valid=0, fifo_level=0. After release with REQ inactive, the FSM is in IDLE.
6. Polarity generics:
   - Stimulus: REQ_ACTIVE_LOW=0, ACK_ACTIVE_LOW=0, INV_MASK=0, aer_bus=9'h1FF.
   - Required: ACK is active-high, evt_data=9'h1FF.
